// File: rtl/chunk_deserializer.sv
// Gathers NUM_CORES chunks from a serial valid/ready stream into one wide word
// for the core array input bus; chunk 0 lands in the least significant slot.
module chunk_deserializer #(
    parameter int WIDTH      = 16,
    parameter int CHUNK_SIZE = 4,
    parameter int NUM_CORES  = 4,
    parameter int CW         = WIDTH * CHUNK_SIZE,
    parameter int IDXW       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CW-1:0]           in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CW*NUM_CORES-1:0] out_data,
    output logic [IDXW-1:0]         chunk_idx,
    output logic                    busy
);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t                  state_q,     state_d;
    logic [IDXW-1:0]         chunk_idx_q, chunk_idx_d;
    logic                    out_valid_q, out_valid_d;
    logic [CW*NUM_CORES-1:0] out_data_q,  out_data_d;
    logic [CW*NUM_CORES-1:0] fill_q,      fill_d;

    logic                    accept_s;
    logic                    last_s;
    logic                    slot_free_s;
    logic [CW*NUM_CORES-1:0] word_s;

    assign in_ready    = (state_q == ST_COLLECT);
    assign accept_s    = in_valid & in_ready;
    assign last_s      = (chunk_idx_q == IDXW'(NUM_CORES - 1));
    assign slot_free_s = ~out_valid_q | out_ready;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign chunk_idx = chunk_idx_q;
    assign busy      = (chunk_idx_q != {IDXW{1'b0}}) | (state_q == ST_PENDING);

    // Word completed by the incoming last chunk, bypassing the fill register
    always_comb begin
        word_s = fill_q;
        word_s[(NUM_CORES-1)*CW +: CW] = in_data;
    end

    // Next-state logic for the collect/pending FSM, fill register and output slot
    always_comb begin
        state_d     = state_q;
        chunk_idx_d = chunk_idx_q;
        out_data_d  = out_data_q;
        fill_d      = fill_q;

        // A transfer empties the slot unless a load below refills it in the same cycle
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (clear) begin
            state_d     = ST_COLLECT;
            chunk_idx_d = {IDXW{1'b0}};
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (accept_s && !last_s) begin
                        for (int i = 0; i < NUM_CORES; i++) begin
                            if (chunk_idx_q == IDXW'(i)) begin
                                fill_d[i*CW +: CW] = in_data;
                            end else begin
                                fill_d[i*CW +: CW] = fill_q[i*CW +: CW];
                            end
                        end
                        chunk_idx_d = chunk_idx_q + IDXW'(1);
                    end else if (accept_s && slot_free_s) begin
                        out_data_d  = word_s;
                        out_valid_d = 1'b1;
                        chunk_idx_d = {IDXW{1'b0}};
                    end else if (accept_s) begin
                        // Consumer still holds the previous word: park the full word
                        fill_d  = word_s;
                        state_d = ST_PENDING;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
                ST_PENDING: begin
                    if (slot_free_s) begin
                        out_data_d  = fill_q;
                        out_valid_d = 1'b1;
                        chunk_idx_d = {IDXW{1'b0}};
                        state_d     = ST_COLLECT;
                    end else begin
                        state_d = ST_PENDING;
                    end
                end
                default: begin
                    state_d     = ST_COLLECT;
                    chunk_idx_d = {IDXW{1'b0}};
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_COLLECT;
            chunk_idx_q <= {IDXW{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {(CW*NUM_CORES){1'b0}};
            fill_q      <= {(CW*NUM_CORES){1'b0}};
        end else begin
            state_q     <= state_d;
            chunk_idx_q <= chunk_idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            fill_q      <= fill_d;
        end
    end

endmodule

// File: tb/tb_chunk_deserializer.sv
// Directed bench for chunk_deserializer: a 4-core build driven from a vector
// table plus hand sequences for async reset and a 1-core build.
module tb_chunk_deserializer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         clear;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;
    logic [1:0]   chunk_idx;
    logic         busy;

    logic         s_clear;
    logic         s_in_valid;
    logic         s_in_ready;
    logic [63:0]  s_in_data;
    logic         s_out_valid;
    logic         s_out_ready;
    logic [63:0]  s_out_data;
    logic [0:0]   s_chunk_idx;
    logic         s_busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chunk_deserializer #(.WIDTH(16), .CHUNK_SIZE(4), .NUM_CORES(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .chunk_idx(chunk_idx),
        .busy(busy)
    );

    chunk_deserializer #(.WIDTH(16), .CHUNK_SIZE(4), .NUM_CORES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(s_clear), .in_valid(s_in_valid),
        .in_ready(s_in_ready), .in_data(s_in_data), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .out_data(s_out_data), .chunk_idx(s_chunk_idx),
        .busy(s_busy)
    );

    typedef struct {
        logic         iv;
        logic [63:0]  d;
        logic         ordy;
        logic         clr;
        logic         e_ov;
        logic         e_ir;
        logic [1:0]   e_idx;
        logic         e_busy;
        logic [255:0] e_od;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [255:0] w4(input logic [63:0] a, input logic [63:0] b,
                                        input logic [63:0] c, input logic [63:0] d);
        return {d, c, b, a};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [63:0] d, input logic o, input logic c,
                       input logic ev, input logic eir, input logic [1:0] eidx,
                       input logic eb, input logic [255:0] eod);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = o; v.clr = c;
        v.e_ov = ev; v.e_ir = eir; v.e_idx = eidx; v.e_busy = eb; v.e_od = eod;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v, input int n);
        @(negedge clk);
        in_valid  = v.iv;
        in_data   = v.d;
        out_ready = v.ordy;
        clear     = v.clr;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d out_valid", n), 256'(out_valid), 256'(v.e_ov));
        chk($sformatf("v%0d in_ready", n),  256'(in_ready),  256'(v.e_ir));
        chk($sformatf("v%0d chunk_idx", n), 256'(chunk_idx), 256'(v.e_idx));
        chk($sformatf("v%0d busy", n),      256'(busy),      256'(v.e_busy));
        chk($sformatf("v%0d out_data", n),  out_data,        v.e_od);
    endtask

    initial begin
        logic [255:0] exp_w;
        logic [63:0]  base;

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 64'h0; out_ready = 1'b0;
        s_clear = 1'b0; s_in_valid = 1'b0; s_in_data = 64'h0; s_out_ready = 1'b0;
        #1;
        chk("reset out_valid", 256'(out_valid), 256'h0);
        chk("reset in_ready",  256'(in_ready),  256'h1);
        chk("reset chunk_idx", 256'(chunk_idx), 256'h0);
        chk("reset busy",      256'(busy),      256'h0);
        chk("reset out_data",  out_data,        256'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic assembly
        add(1'b1, 64'h1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 256'h0);
        add(1'b1, 64'h2, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 256'h0);
        add(1'b1, 64'h3, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 256'h0);
        add(1'b1, 64'h4, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, w4(64'h1, 64'h2, 64'h3, 64'h4));
        add(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, w4(64'h1, 64'h2, 64'h3, 64'h4));

        // Streaming: 16 chunks back-to-back, a word every 4th accept
        exp_w = w4(64'h1, 64'h2, 64'h3, 64'h4);
        base  = 64'h10;
        for (int k = 1; k <= 16; k++) begin
            if (k % 4 == 0)
                exp_w = w4(base + 64'(k - 3), base + 64'(k - 2), base + 64'(k - 1), base + 64'(k));
            add(1'b1, base + 64'(k), 1'b1, 1'b0, (k % 4 == 0), 1'b1, 2'(k % 4), (k % 4 != 0), exp_w);
        end
        add(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, exp_w);

        // Backpressure: word0 held, word1 parks in PENDING, blocked input ignored
        add(1'b1, 64'h101, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, exp_w);
        add(1'b1, 64'h102, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, exp_w);
        add(1'b1, 64'h103, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, exp_w);
        exp_w = w4(64'h101, 64'h102, 64'h103, 64'h104);
        add(1'b1, 64'h104, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, exp_w);
        add(1'b1, 64'h105, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, exp_w);
        add(1'b1, 64'h106, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1, exp_w);
        add(1'b1, 64'h107, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, exp_w);
        add(1'b1, 64'h108, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, exp_w);
        add(1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 1'b1, exp_w);
        exp_w = w4(64'h105, 64'h106, 64'h107, 64'h108);
        add(1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, exp_w);
        add(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, exp_w);

        // Clear mid-word, chunk presented with clear is dropped
        add(1'b1, 64'h201, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, exp_w);
        add(1'b1, 64'h202, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, exp_w);
        add(1'b1, 64'h2FF, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, exp_w);
        add(1'b1, 64'hA, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1, exp_w);
        add(1'b1, 64'hB, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, exp_w);
        add(1'b1, 64'hC, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1, exp_w);
        exp_w = w4(64'hA, 64'hB, 64'hC, 64'hD);
        add(1'b1, 64'hD, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, exp_w);
        add(1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, exp_w);

        foreach (vecs[i]) apply(vecs[i], i);

        // Async reset while PENDING with out_valid high
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_data  = 64'h300 + 64'(k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pend in_ready",  256'(in_ready),  256'h0);
        chk("pend out_valid", 256'(out_valid), 256'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", 256'(out_valid), 256'h0);
        chk("arst out_data",  out_data,        256'h0);
        chk("arst in_ready",  256'(in_ready),  256'h1);
        chk("arst chunk_idx", 256'(chunk_idx), 256'h0);
        chk("arst busy",      256'(busy),      256'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post-rst out_valid", 256'(out_valid), 256'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 64'h400 + 64'(k);
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("post-rst word valid", 256'(out_valid), 256'h1);
        chk("post-rst word", out_data, w4(64'h401, 64'h402, 64'h403, 64'h404));

        // NUM_CORES=1 build
        s_out_ready = 1'b1;
        s_in_valid  = 1'b1;
        s_in_data   = 64'hAA;
        @(posedge clk);
        #1;
        chk("n1 AA valid", 256'(s_out_valid), 256'h1);
        chk("n1 AA data",  256'(s_out_data),  256'hAA);
        @(negedge clk);
        s_in_data = 64'hBB;
        @(posedge clk);
        #1;
        chk("n1 BB valid", 256'(s_out_valid), 256'h1);
        chk("n1 BB data",  256'(s_out_data),  256'hBB);
        @(negedge clk);
        s_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("n1 drained", 256'(s_out_valid), 256'h0);
        @(negedge clk);
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 64'hCC;
        @(negedge clk);
        s_in_data = 64'hDD;
        @(posedge clk);
        #1;
        chk("n1 pend in_ready", 256'(s_in_ready), 256'h0);
        chk("n1 pend busy",     256'(s_busy),     256'h1);
        chk("n1 pend data",     256'(s_out_data), 256'hCC);
        @(negedge clk);
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("n1 DD valid",    256'(s_out_valid), 256'h1);
        chk("n1 DD data",     256'(s_out_data),  256'hDD);
        chk("n1 DD in_ready", 256'(s_in_ready),  256'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
